q_measure_seq: RTL and testbench

- Plant-side responder for the secant current controller.
- Takes the controller's i_ref, drives it to the current DAC and waits a settling interval.
- Averages 2^AVG_LOG2 charge ADC samples, then returns q_measured with a one-cycle ready pulse that advances the controller's state.
- Sits between the secant controller and the analog front-end (DAC out, ADC in).

---
 rtl/q_meas_pkg.sv | 12 +
 rtl/q_measure_seq_if.sv | 22 ++
 rtl/sample_averager.sv | 36 +++
 rtl/q_measure_seq.sv | 116 +++++++++++
 tb/tb_q_measure_seq.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/q_meas_pkg.sv
// q_meas_pkg: shared state type, default parameters and width helper for the charge measurement responder
package q_meas_pkg;
    localparam int BUS_WIDTH_DEF     = 10;
    localparam int SETTLE_CYCLES_DEF = 16;
    localparam int AVG_LOG2_DEF      = 3;
    localparam int TIMEOUT_DEF       = 64;
    typedef enum logic [1:0] {IDLE, SETTLE, ACQUIRE, PUBLISH} state_t;
    // Accumulator width that holds 2^avg_log2 full-scale samples without overflow.
    function automatic int acc_width(input int bus_width, input int avg_log2);
        return bus_width + avg_log2;
    endfunction
endpackage

// File: rtl/q_measure_seq_if.sv
// q_measure_seq_if: controller and analog front-end bundle of the measurement responder
//   master drives en, i_ref, adc_sample, adc_valid; slave drives dac_code, q_measured, ready, timeout
interface q_measure_seq_if import q_meas_pkg::*; #(
    parameter int BUS_WIDTH = BUS_WIDTH_DEF
);
    logic                 en;
    logic [BUS_WIDTH-1:0] i_ref;
    logic [BUS_WIDTH-1:0] adc_sample;
    logic                 adc_valid;
    logic [BUS_WIDTH-1:0] dac_code;
    logic [BUS_WIDTH-1:0] q_measured;
    logic                 ready;
    logic                 timeout;
    modport master (
        output en, i_ref, adc_sample, adc_valid,
        input  dac_code, q_measured, ready, timeout
    );
    modport slave (
        input  en, i_ref, adc_sample, adc_valid,
        output dac_code, q_measured, ready, timeout
    );
endinterface

// File: rtl/sample_averager.sv
// sample_averager: accumulates 2^AVG_LOG2 samples and presents their round-half-up mean
//   clk/rst: clock and sync reset; clear: zero sum and count; accept: add sample
//   full: this accept completes the set; mean: rounded average of the stored sum
module sample_averager import q_meas_pkg::*; #(
    parameter int BUS_WIDTH = BUS_WIDTH_DEF,
    parameter int AVG_LOG2  = AVG_LOG2_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 accept,
    input  logic [BUS_WIDTH-1:0] sample,
    output logic                 full,
    output logic [BUS_WIDTH-1:0] mean
);
    localparam int AW = acc_width(BUS_WIDTH, AVG_LOG2);
    localparam int N  = 1 << AVG_LOG2;
    logic [AW-1:0]     acc_q, acc_d;
    logic [AVG_LOG2:0] cnt_q, cnt_d;
    always_comb begin
        acc_d = clear ? '0 : accept ? acc_q + AW'(sample) : acc_q;
        cnt_d = clear ? '0 : accept ? cnt_q + (AVG_LOG2 + 1)'(1) : cnt_q;
        full  = accept && (cnt_q == (AVG_LOG2 + 1)'(N - 1));
        // One spare bit absorbs the half-LSB rounding add; the result always fits BUS_WIDTH.
        mean  = BUS_WIDTH'(({1'b0, acc_q} + (AW + 1)'(N / 2)) >> AVG_LOG2);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/q_measure_seq.sv
// q_measure_seq: drives i_ref to the DAC, waits to settle, averages ADC samples and publishes q_measured
//   clk/rst: clock and sync active-high reset
//   bus (slave): en, i_ref, adc_sample, adc_valid in; dac_code, q_measured, ready, timeout out
module q_measure_seq import q_meas_pkg::*; #(
    parameter int BUS_WIDTH     = BUS_WIDTH_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int AVG_LOG2      = AVG_LOG2_DEF,
    parameter int TIMEOUT       = TIMEOUT_DEF
) (
    input logic            clk,
    input logic            rst,
    q_measure_seq_if.slave bus
);
    localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
    localparam int IW = $clog2(TIMEOUT);
    state_t               state_q, state_d;
    logic [SW-1:0]        settle_q, settle_d;
    logic [IW-1:0]        idle_q, idle_d;
    logic [BUS_WIDTH-1:0] dac_q, dac_d, q_q, q_d, mean;
    logic                 ready_q, ready_d, timeout_q, timeout_d;
    logic                 clear, accept, full, changed;
    sample_averager #(.BUS_WIDTH(BUS_WIDTH), .AVG_LOG2(AVG_LOG2)) u_avg (
        .clk(clk),
        .rst(rst),
        .clear(clear),
        .accept(accept),
        .sample(bus.adc_sample),
        .full(full),
        .mean(mean)
    );
    assign changed = bus.i_ref != dac_q;
    // Priority inside SETTLE/ACQUIRE: en low, then i_ref change, then starvation, then sample accept.
    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        idle_d    = idle_q;
        dac_d     = dac_q;
        q_d       = q_q;
        ready_d   = 1'b0;
        timeout_d = 1'b0;
        clear     = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    dac_d    = bus.i_ref;
                    settle_d = SW'(SETTLE_CYCLES - 1);
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (!bus.en) begin
                    state_d = IDLE;
                end else if (changed) begin
                    dac_d    = bus.i_ref;
                    settle_d = SW'(SETTLE_CYCLES - 1);
                end else if (settle_q == '0) begin
                    clear   = 1'b1;
                    idle_d  = '0;
                    state_d = ACQUIRE;
                end else begin
                    settle_d = settle_q - SW'(1);
                end
            end
            ACQUIRE: begin
                if (!bus.en) begin
                    state_d = IDLE;
                end else if (changed) begin
                    dac_d    = bus.i_ref;
                    settle_d = SW'(SETTLE_CYCLES - 1);
                    state_d  = SETTLE;
                end else if (!bus.adc_valid && idle_q == IW'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    settle_d  = SW'(SETTLE_CYCLES - 1);
                    state_d   = SETTLE;
                end else if (bus.adc_valid) begin
                    accept  = 1'b1;
                    idle_d  = '0;
                    state_d = full ? PUBLISH : ACQUIRE;
                end else begin
                    idle_d = idle_q + IW'(1);
                end
            end
            PUBLISH: begin
                ready_d  = 1'b1;
                q_d      = mean;
                dac_d    = bus.en ? bus.i_ref : dac_q;
                settle_d = SW'(SETTLE_CYCLES - 1);
                state_d  = bus.en ? SETTLE : IDLE;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            settle_q  <= '0;
            idle_q    <= '0;
            dac_q     <= '0;
            q_q       <= '0;
            ready_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            idle_q    <= idle_d;
            dac_q     <= dac_d;
            q_q       <= q_d;
            ready_q   <= ready_d;
            timeout_q <= timeout_d;
        end
    end
    assign bus.dac_code   = dac_q;
    assign bus.q_measured = q_q;
    assign bus.ready      = ready_q;
    assign bus.timeout    = timeout_q;
endmodule

// File: tb/tb_q_measure_seq.sv
// tb_q_measure_seq: scoreboard bench for q_measure_seq with randomized samples and directed corner cases
module tb_q_measure_seq;
    import q_meas_pkg::*;
    localparam int BW = BUS_WIDTH_DEF;
    localparam int S  = SETTLE_CYCLES_DEF;
    localparam int AL = AVG_LOG2_DEF;
    localparam int N  = 1 << AL;
    localparam int TO = TIMEOUT_DEF;
    typedef struct {
        int kind;
        int val;
        int cyc;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    q_measure_seq_if #(.BUS_WIDTH(BW)) bus ();
    q_measure_seq #(.BUS_WIDTH(BW), .SETTLE_CYCLES(S), .AVG_LOG2(AL), .TIMEOUT(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    exp_t sb[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int lat = 0;
    int cur_iref = 0;
    int last_q = 0;
    int smp[N];
    int gap[N];
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    // Monitor: every ready/timeout pulse must match the oldest expected event.
    always @(negedge clk) begin
        int k;
        exp_t e;
        if (bus.ready || bus.timeout) begin
            check("ready_timeout_exclusive", int'(bus.ready & bus.timeout), 0);
            k = bus.ready ? 0 : 1;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_%s: got pulse expected none (cycle %0d)", k ? "timeout" : "ready", cyc);
            end else begin
                e = sb.pop_front();
                check("event_kind", k, e.kind);
                check("event_cycle", cyc, e.cyc);
                if (k == 0) check("q_measured", int'(bus.q_measured), e.val);
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic junk();
        bus.adc_valid  = 1'($urandom_range(0, 1));
        bus.adc_sample = BW'($urandom);
    endtask
    function automatic int exp_mean();
        int s = 0;
        for (int i = 0; i < N; i++) s += smp[i];
        return (s + N / 2) / N;
    endfunction
    task automatic settle_phase();
        repeat (S) begin
            junk();
            tick();
        end
    endtask
    task automatic feed(input int cnt, output int n);
        n = 0;
        for (int i = 0; i < cnt; i++) begin
            repeat (gap[i]) begin
                bus.adc_valid  = 1'b0;
                bus.adc_sample = BW'($urandom);
                tick();
                n++;
            end
            bus.adc_valid  = 1'b1;
            bus.adc_sample = BW'(smp[i]);
            tick();
            n++;
        end
    endtask
    // Runs one full measurement from a latch edge; ready appears S + acquire cycles + 1 edges later.
    task automatic acquire_publish(input int nxt_iref, input bit nxt_en);
        int n;
        exp_t e;
        settle_phase();
        feed(N, n);
        e.kind = 0;
        e.val  = exp_mean();
        e.cyc  = lat + S + n + 1;
        sb.push_back(e);
        last_q = e.val;
        bus.i_ref = BW'(nxt_iref);
        bus.en    = nxt_en;
        junk();
        tick();
        if (nxt_en) begin
            lat = cyc;
            cur_iref = nxt_iref;
            check("dac_relatch", int'(bus.dac_code), nxt_iref);
        end
    endtask
    task automatic fill_const(input int v);
        for (int i = 0; i < N; i++) begin
            smp[i] = v;
            gap[i] = 0;
        end
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end
    initial begin
        int n;
        exp_t e;
        bus.en = 1'b0;
        bus.i_ref = '0;
        bus.adc_valid = 1'b0;
        bus.adc_sample = '0;
        tick();
        tick();
        check("rst_dac", int'(bus.dac_code), 0);
        check("rst_q", int'(bus.q_measured), 0);
        check("rst_ready", int'(bus.ready), 0);
        check("rst_timeout", int'(bus.timeout), 0);
        bus.en = 1'b1;
        bus.i_ref = BW'(300);
        tick();
        check("rst_priority_dac", int'(bus.dac_code), 0);
        rst = 1'b0;
        tick();
        lat = cyc;
        cur_iref = 300;
        check("first_latch_dac", int'(bus.dac_code), 300);
        fill_const(512);
        acquire_publish(300, 1'b1);
        for (int i = 0; i < N; i++) begin
            smp[i] = i < N / 2 ? 100 : 101;
            gap[i] = 0;
        end
        acquire_publish(300, 1'b1);
        fill_const(1023);
        acquire_publish(300, 1'b1);
        fill_const(0);
        acquire_publish(300, 1'b1);
        for (int r = 0; r < 2; r++) begin
            fill_const(200);
            for (int i = 1; i < N; i++) gap[i] = 1;
            acquire_publish(r == 0 ? 310 : 300, 1'b1);
        end
        settle_phase();
        for (int i = 0; i < N; i++) begin
            smp[i] = $urandom_range(0, 1023);
            gap[i] = 0;
        end
        feed(5, n);
        bus.i_ref = BW'(700);
        bus.adc_valid = 1'b1;
        tick();
        lat = cyc;
        cur_iref = 700;
        check("change_dac", int'(bus.dac_code), 700);
        for (int i = 0; i < N; i++) smp[i] = $urandom_range(0, 1023);
        acquire_publish(700, 1'b1);
        settle_phase();
        feed(N - 1, n);
        bus.i_ref = BW'(650);
        bus.adc_valid = 1'b1;
        bus.adc_sample = BW'(smp[N - 1]);
        tick();
        lat = cyc;
        cur_iref = 650;
        check("final_sample_change_dac", int'(bus.dac_code), 650);
        acquire_publish(650, 1'b1);
        settle_phase();
        feed(2, n);
        e.kind = 1;
        e.val  = 0;
        e.cyc  = lat + S + 2 + TO;
        sb.push_back(e);
        bus.adc_valid = 1'b0;
        repeat (TO) tick();
        lat = cyc;
        check("timeout_dac_held", int'(bus.dac_code), cur_iref);
        for (int i = 0; i < N; i++) begin
            smp[i] = $urandom_range(0, 1023);
            gap[i] = $urandom_range(0, 2);
        end
        acquire_publish(cur_iref, 1'b1);
        repeat (5) begin
            junk();
            tick();
        end
        bus.en = 1'b0;
        tick();
        bus.i_ref = BW'(555);
        repeat (3) begin
            junk();
            tick();
        end
        check("en_drop_dac_held", int'(bus.dac_code), cur_iref);
        check("en_drop_q_held", int'(bus.q_measured), last_q);
        bus.en = 1'b1;
        tick();
        lat = cyc;
        cur_iref = 555;
        check("en_resume_dac", int'(bus.dac_code), 555);
        settle_phase();
        fill_const(77);
        feed(3, n);
        rst = 1'b1;
        tick();
        check("midrst_dac", int'(bus.dac_code), 0);
        check("midrst_q", int'(bus.q_measured), 0);
        check("midrst_ready", int'(bus.ready), 0);
        check("midrst_timeout", int'(bus.timeout), 0);
        rst = 1'b0;
        tick();
        lat = cyc;
        check("post_rst_latch_dac", int'(bus.dac_code), cur_iref);
        for (int r = 0; r < 12; r++) begin
            int nxt;
            for (int i = 0; i < N; i++) begin
                smp[i] = $urandom_range(0, 3) == 0 ? ($urandom_range(0, 1) ? 1023 : 0) : $urandom_range(0, 1023);
                gap[i] = $urandom_range(0, 3);
            end
            nxt = $urandom_range(0, 3) == 0 ? cur_iref : $urandom_range(0, 1023);
            acquire_publish(nxt, r != 11);
        end
        repeat (4) tick();
        check("scoreboard_drained", sb.size(), 0);
        check("final_q_held", int'(bus.q_measured), last_q);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
